// File: rtl/tdm_demux4.sv
// tdm_demux4: receive-side 1-to-4 time-division demultiplexer.
// A slot-serialised stream (one WIDTH-bit slot per valid beat, slot 0 flagged
// by in_sync) is unpacked into four parallel lanes. A completed frame is
// published on out_data together with a one-cycle out_valid pulse. Sync
// violations raise a one-cycle frame_err pulse.
module tdm_demux4 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    input  logic               in_sync,
    output logic [4*WIDTH-1:0] out_data,
    output logic               out_valid,
    output logic               frame_err,
    output logic               locked,
    output logic [1:0]         slot_idx
);

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lane0;
    logic [WIDTH-1:0] lane1;
    logic [WIDTH-1:0] lane2;

    // Alignment FSM, lane capture and registered frame/error outputs.
    // Lane 3 is never stored: the slot-3 beat goes straight into out_data so
    // that back-to-back frames need no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            lane0     <= '0;
            lane1     <= '0;
            lane2     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            locked    <= 1'b0;
            slot_idx  <= '0;
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                HUNT: begin
                    if (in_valid && in_sync) begin
                        lane0    <= in_data;
                        slot_idx <= 2'd1;
                        locked   <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        if (in_sync) begin
                            // Sync mid-frame abandons the partial frame and
                            // restarts alignment on this beat.
                            if (slot_idx != 2'd0) begin
                                frame_err <= 1'b1;
                            end
                            lane0    <= in_data;
                            slot_idx <= 2'd1;
                        end else if (slot_idx == 2'd0) begin
                            // Missing sync: alignment lost, beat dropped.
                            frame_err <= 1'b1;
                            locked    <= 1'b0;
                            slot_idx  <= 2'd0;
                            state     <= HUNT;
                        end else begin
                            unique case (slot_idx)
                                2'd1: begin
                                    lane1    <= in_data;
                                    slot_idx <= 2'd2;
                                end
                                2'd2: begin
                                    lane2    <= in_data;
                                    slot_idx <= 2'd3;
                                end
                                default: begin
                                    out_data  <= {in_data, lane2, lane1, lane0};
                                    out_valid <= 1'b1;
                                    slot_idx  <= 2'd0;
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    state    <= HUNT;
                    locked   <= 1'b0;
                    slot_idx <= '0;
                end
            endcase
        end
    end

endmodule
